// File: rtl/pe_ctrl_pkg.sv
// rtl/pe_ctrl_pkg.sv - shared types and constants for the PE02 context sequencer
package pe_ctrl_pkg;

    localparam int CTRL_WIDTH = 11;

    // Control word field widths: output(3)_op1(3)_op2(3)_opcode(2)
    localparam int OUT_W = 3;
    localparam int OP1_W = 3;
    localparam int OP2_W = 3;
    localparam int OPC_W = 2;

    localparam logic [OPC_W-1:0] OPC_ADD = 2'b00;  // add / route
    localparam logic [OPC_W-1:0] OPC_MUL = 2'b10;
    localparam logic [OPC_W-1:0] OPC_DIV = 2'b11;

    typedef struct packed {
        logic [OUT_W-1:0] out_sel;
        logic [OP1_W-1:0] op1_sel;
        logic [OP2_W-1:0] op2_sel;
        logic [OPC_W-1:0] opcode;
    } pe_ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/pe_ctx_mem.sv
// rtl/pe_ctx_mem.sv - context register file, one sync write port, one async read port
module pe_ctx_mem #(
    parameter  int DEPTH      = 16,
    parameter  int CTRL_WIDTH = 11,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [CTRL_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [CTRL_WIDTH-1:0] rdata
);

    logic [CTRL_WIDTH-1:0] mem [DEPTH];

    // Contents survive reset so a program can be replayed after an abort
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_ctrl_sequencer.sv
// rtl/pe_ctrl_sequencer.sv - issues a looped program of PE02 control words
module pe_ctrl_sequencer #(
    parameter  int CTRL_WIDTH = 11,
    parameter  int DEPTH      = 16,
    parameter  int LOOP_W     = 8,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [CTRL_WIDTH-1:0] cfg_wdata,
    input  logic [ADDR_W:0]       seq_len,
    input  logic [LOOP_W-1:0]     loop_cnt,
    input  logic                  start,
    input  logic                  stall,
    output logic [CTRL_WIDTH-1:0] ctrl_out,
    output logic                  ctrl_valid,
    output logic [ADDR_W-1:0]     pc,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    import pe_ctrl_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    seq_state_t            state;
    logic [ADDR_W:0]       len_q;
    logic [LOOP_W-1:0]     loops_q;
    logic [LOOP_W-1:0]     iter;
    logic                  last_q;     // the word now on ctrl_out is the final one
    logic [ADDR_W:0]       seq_len_clip;
    logic                  pc_at_end;
    logic                  mem_we;
    logic [CTRL_WIDTH-1:0] rd_data;

    assign seq_len_clip = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
    assign pc_at_end    = ({1'b0, pc} == (len_q - LEN_ONE));
    assign mem_we       = cfg_we && (state != RUN);

    // pc is 0 whenever the FSM is idle, so it also addresses the first word at start
    pe_ctx_mem #(
        .DEPTH      (DEPTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_ctx_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (pc),
        .rdata (rd_data)
    );

    // Flag writes that arrive while a program is running; they are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && (state == RUN);
        end
    end

    // Sequencer FSM: start latch, word issue with stall bubbles, loop counting, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ctrl_out   <= '0;
            ctrl_valid <= 1'b0;
            pc         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            len_q      <= '0;
            loops_q    <= '0;
            iter       <= '0;
            last_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q   <= seq_len_clip;
                        loops_q <= loop_cnt;
                        if (seq_len_clip == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            ctrl_out   <= rd_data;
                            ctrl_valid <= 1'b1;
                            busy       <= 1'b1;
                            state      <= RUN;
                            last_q     <= (seq_len_clip == LEN_ONE) && (loop_cnt == '0);
                            // A one-word program wraps immediately, finishing iteration 0
                            if (seq_len_clip == LEN_ONE) begin
                                pc   <= '0;
                                iter <= LOOP_W'(1);
                            end else begin
                                pc   <= {{(ADDR_W-1){1'b0}}, 1'b1};
                                iter <= '0;
                            end
                        end
                    end
                end
                RUN: begin
                    if (last_q) begin
                        // Completion is not delayed by stall
                        ctrl_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        last_q     <= 1'b0;
                        pc         <= '0;
                        state      <= DONE;
                    end else if (stall) begin
                        ctrl_valid <= 1'b0;
                    end else begin
                        ctrl_out   <= rd_data;
                        ctrl_valid <= 1'b1;
                        // Compare before incrementing so iter never needs to exceed loops_q
                        last_q     <= pc_at_end && (iter == loops_q);
                        if (pc_at_end) begin
                            pc   <= '0;
                            iter <= iter + 1'b1;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// tb/tb_pe_ctrl_sequencer.sv - self-checking bench for pe_ctrl_sequencer
module tb_pe_ctrl_sequencer;

    localparam int CW    = 11;
    localparam int DEPTH = 16;
    localparam int LW    = 8;
    localparam int AW    = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          cfg_we    = 1'b0;
    logic [AW-1:0] cfg_addr  = '0;
    logic [CW-1:0] cfg_wdata = '0;
    logic [AW:0]   seq_len   = '0;
    logic [LW-1:0] loop_cnt  = '0;
    logic          start     = 1'b0;
    logic          stall     = 1'b0;
    logic [CW-1:0] ctrl_out;
    logic          ctrl_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          cfg_err;

    always #5 clk = ~clk;

    pe_ctrl_sequencer #(
        .CTRL_WIDTH (CW),
        .DEPTH      (DEPTH),
        .LOOP_W     (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .seq_len    (seq_len),
        .loop_cnt   (loop_cnt),
        .start      (start),
        .stall      (stall),
        .ctrl_out   (ctrl_out),
        .ctrl_valid (ctrl_valid),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    // Reference model: counts issued words of a len*(loops+1) stream
    logic [CW-1:0] tmem [DEPTH];
    int            m_phase  = 0;   // 0 idle, 1 run, 2 done
    int            m_len    = 0;
    int            m_total  = 0;
    int            m_issued = 0;
    logic          m_valid  = 1'b0;
    logic          m_busy   = 1'b0;
    logic          m_done   = 1'b0;
    logic          m_err    = 1'b0;
    logic [CW-1:0] m_out    = '0;
    logic          m_wr_ok;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_len = 0; m_total = 0; m_issued = 0;
            m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_out = '0;
        end else begin
            m_wr_ok = cfg_we && (m_phase != 1);
            m_err   = cfg_we && (m_phase == 1);
            m_done  = 1'b0;
            case (m_phase)
                0: if (start) begin
                    m_len   = (int'(seq_len) > DEPTH) ? DEPTH : int'(seq_len);
                    m_total = m_len * (int'(loop_cnt) + 1);
                    if (m_len == 0) begin
                        m_phase = 2; m_done = 1'b1;
                    end else begin
                        m_out = tmem[0]; m_valid = 1'b1; m_busy = 1'b1;
                        m_issued = 1; m_phase = 1;
                    end
                end
                1: if (m_issued == m_total) begin
                    m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b1; m_phase = 2;
                end else if (stall) begin
                    m_valid = 1'b0;
                end else begin
                    m_out = tmem[m_issued % m_len];
                    m_issued++;
                    m_valid = 1'b1;
                end
                default: m_phase = 0;
            endcase
            if (m_wr_ok) tmem[cfg_addr] = cfg_wdata;
        end
    end

    task automatic cmp_all();
        check("ctrl_valid", ctrl_valid, m_valid);
        check("ctrl_out",   ctrl_out,   m_out);
        check("busy",       busy,       m_busy);
        check("done",       done,       m_done);
        check("cfg_err",    cfg_err,    m_err);
        check("pc",         pc,         (m_phase == 1) ? (m_issued % m_len) : 0);
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic wr(input int a, input logic [CW-1:0] d);
        cfg_we = 1'b1; cfg_addr = a[AW-1:0]; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_run(input int len, input int loops, input int stall_pct, input bit noise,
                          output int nvalid, output int done_at);
        int cyc;
        seq_len = len[AW:0]; loop_cnt = loops[LW-1:0]; start = 1'b1; stall = 1'b0; cfg_we = 1'b0;
        tick();
        start = 1'b0; seq_len = 5'($urandom); loop_cnt = 8'($urandom);
        nvalid = 0; done_at = -1; cyc = 1;
        while (done_at < 0 && cyc < 2000) begin
            if (ctrl_valid) nvalid++;
            if (done) begin
                done_at = cyc;
            end else begin
                stall = ($urandom_range(99) < stall_pct);
                if (noise) begin
                    start     = 1'($urandom_range(1));
                    cfg_we    = ($urandom_range(3) == 0);
                    cfg_addr  = 4'($urandom);
                    cfg_wdata = 11'($urandom);
                end
                tick();
                cyc++;
            end
        end
        stall = 1'b0; start = 1'b0; cfg_we = 1'b0;
        if (done_at < 0) check("run_timeout", 0, 1);
        tick();
    endtask

    typedef struct {
        int len;
        int loops;
        int exp_valid;
        int exp_done_at;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nv, da, len, loops;

        vecs[0] = '{3, 0, 3, 4};
        vecs[1] = '{3, 2, 9, 10};
        vecs[2] = '{0, 0, 0, 1};
        vecs[3] = '{20, 0, 16, 17};
        vecs[4] = '{1, 0, 1, 2};
        vecs[5] = '{1, 255, 256, 257};
        vecs[6] = '{16, 1, 32, 33};
        vecs[7] = '{2, 3, 8, 9};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctrl_out", ctrl_out, 0);
        check("rst_valid", ctrl_valid, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) wr(i, 11'($urandom));
        wr(0, 11'h304); wr(1, 11'h62A); wr(2, 11'h46F);

        // Basic three-word program
        seq_len = 5'd3; loop_cnt = 8'd0; start = 1'b1;
        tick(); start = 1'b0;
        check("t1_w0_valid", ctrl_valid, 1); check("t1_w0", ctrl_out, 11'h304); check("t1_w0_busy", busy, 1);
        tick(); check("t1_w1", ctrl_out, 11'h62A); check("t1_w1_valid", ctrl_valid, 1);
        tick(); check("t1_w2", ctrl_out, 11'h46F); check("t1_w2_done", done, 0);
        tick(); check("t1_done", done, 1); check("t1_done_valid", ctrl_valid, 0); check("t1_done_busy", busy, 0);
        tick(); check("t1_done_once", done, 0);

        // Stall bubbles after the first word
        seq_len = 5'd3; start = 1'b1;
        tick(); start = 1'b0; stall = 1'b1;
        check("t3_w0", ctrl_out, 11'h304);
        tick(); check("t3_b0_valid", ctrl_valid, 0); check("t3_b0_hold", ctrl_out, 11'h304);
        tick(); check("t3_b1_valid", ctrl_valid, 0); check("t3_b1_hold", ctrl_out, 11'h304);
        stall = 1'b0;
        tick(); check("t3_w1", ctrl_out, 11'h62A); check("t3_w1_valid", ctrl_valid, 1);
        tick(); check("t3_w2", ctrl_out, 11'h46F);
        tick(); check("t3_done", done, 1);
        tick();

        // Write during RUN is rejected
        seq_len = 5'd3; start = 1'b1;
        tick(); start = 1'b0;
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = 11'h7FF;
        tick(); cfg_we = 1'b0;
        check("t4_err", cfg_err, 1); check("t4_w1", ctrl_out, 11'h62A);
        tick(); check("t4_err_pulse", cfg_err, 0);
        tick(); check("t4_done", done, 1);
        tick();
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); check("t4_rerun_w1", ctrl_out, 11'h62A);
        tick(); tick(); tick();

        // Reset during the second word aborts without done
        seq_len = 5'd3; start = 1'b1;
        tick(); start = 1'b0;
        tick(); check("t6_w1_before_rst", ctrl_out, 11'h62A);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_out", ctrl_out, 0); check("t6_rst_valid", ctrl_valid, 0);
        check("t6_rst_busy", busy, 0); check("t6_rst_pc", pc, 0); check("t6_rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        start = 1'b1;
        tick(); start = 1'b0;
        check("t6_replay_w0", ctrl_out, 11'h304); check("t6_replay_valid", ctrl_valid, 1);
        tick(); tick(); tick(); tick();

        // Table of lengths and loop counts, no stalls
        for (int i = 0; i < 8; i++) begin
            do_run(vecs[i].len, vecs[i].loops, 0, 1'b0, nv, da);
            check($sformatf("vec%0d_nvalid", i), nv, vecs[i].exp_valid);
            check($sformatf("vec%0d_done_at", i), da, vecs[i].exp_done_at);
        end

        // Randomized programs, stalls, ignored starts and rejected writes
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < 3; k++) wr($urandom_range(DEPTH-1), 11'($urandom));
            len   = $urandom_range(20);
            loops = $urandom_range(3);
            do_run(len, loops, 25, 1'b1, nv, da);
            check($sformatf("rand%0d_nvalid", r), nv, ((len > DEPTH) ? DEPTH : len) * (loops + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
